// File: rtl/i2c_vip_pkg.sv
// Shared constants and FSM state encoding for the I2C slave VIP.
package i2c_vip_pkg;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ADDR     = 3'd1;
    localparam state_t ST_ADDR_ACK = 3'd2;
    localparam state_t ST_WR_DATA  = 3'd3;
    localparam state_t ST_WR_ACK   = 3'd4;
    localparam state_t ST_RD_DATA  = 3'd5;
    localparam state_t ST_RD_ACK   = 3'd6;
    localparam state_t ST_IGNORE   = 3'd7;

endpackage

// File: rtl/i2c_slave_vip_core_sync.sv
// Two-flop synchronizer with rise/fall detection for one I2C pin.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // Synchronize the pin and keep the previous sample; the bus idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            // Anything other than a solid 0 (Z/X) counts as released.
            meta  <= (pin !== 1'b0);
            level <= meta;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/i2c_slave_vip_core.sv
// Behavioural I2C slave: acknowledges its address, captures write bytes
// into a 16-bit register and returns that register on reads.
module i2c_slave_vip_core
    import i2c_vip_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] i2c_data
);

    logic   scl_s, scl_rise, scl_fall;
    logic   sda_s, sda_rise, sda_fall;
    logic   start, stop;
    state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] shift_nxt;
    logic [7:0] rd_shift;
    logic       rd_hi;
    logic       rw;
    logic       ack_phase;
    logic       sda_low;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (scl),
        .level (scl_s),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .pin   (sda),
        .level (sda_s),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start     = sda_fall & scl_s;
    assign stop      = sda_rise & scl_s;
    assign shift_nxt = {shift[6:0], sda_s};

    // Open-drain: only ever pull low or float.
    assign sda = sda_low ? 1'b0 : 1'bz;

    // Protocol FSM; START/STOP take priority over bit-level activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rd_shift  <= 8'h00;
            rd_hi     <= 1'b0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            sda_low   <= 1'b0;
            i2c_data  <= 16'h0000;
        end else if (start) begin
            state     <= ST_ADDR;
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
            sda_low   <= 1'b0;
        end else if (stop) begin
            state     <= ST_IDLE;
            ack_phase <= 1'b0;
            sda_low   <= 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift   <= shift_nxt;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ack_phase <= 1'b0;
                            if (shift_nxt[7:1] == SLAVE_ADDR) begin
                                rw    <= shift_nxt[0];
                                state <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                end
                // First SCL fall (end of bit 8) drives ACK, second releases it.
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_low   <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= 3'd0;
                            if (state == ST_ADDR_ACK && rw) begin
                                rd_shift <= i2c_data[15:8];
                                rd_hi    <= 1'b1;
                                sda_low  <= ~i2c_data[15];
                                state    <= ST_RD_DATA;
                            end else begin
                                sda_low <= 1'b0;
                                state   <= ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift   <= shift_nxt;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            i2c_data  <= {i2c_data[7:0], shift_nxt};
                            ack_phase <= 1'b0;
                            state     <= ST_WR_ACK;
                        end
                    end
                end
                // MSB is already on the pin at entry; count rises, shift on falls.
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_low   <= 1'b0;
                            ack_phase <= 1'b0;
                            state     <= ST_RD_ACK;
                        end else begin
                            rd_shift <= {rd_shift[6:0], 1'b0};
                            sda_low  <= ~rd_shift[6];
                        end
                    end
                end
                // ack_phase marks "master ACKed, next byte loaded, drive on fall".
                ST_RD_ACK: begin
                    sda_low <= 1'b0;
                    if (scl_rise && !ack_phase) begin
                        if (sda_s) begin
                            state <= ST_IGNORE;
                        end else begin
                            rd_shift  <= rd_hi ? i2c_data[7:0] : i2c_data[15:8];
                            rd_hi     <= ~rd_hi;
                            ack_phase <= 1'b1;
                        end
                    end else if (scl_fall && ack_phase) begin
                        sda_low   <= ~rd_shift[7];
                        bit_cnt   <= 3'd0;
                        ack_phase <= 1'b0;
                        state     <= ST_RD_DATA;
                    end
                end
                default: begin
                    sda_low <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_vip_core.sv
// Self-checking bench: bit-banged I2C master with a scoreboard of expected
// ACK bits, read bytes and capture-register values.
module tb_i2c_slave_vip_core;

    localparam int Q = 100;  // quarter SCL period (10 clk periods)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda = 1'b1;
    wire         sda;
    logic [15:0] i2c_data;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_vip_core #(
        .SLAVE_ADDR (7'h50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .i2c_data (i2c_data)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [15:0] obs);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            check_val(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic bus_start();
        #(Q) m_sda = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) m_sda = 1'b0;
        #(Q) scl = 1'b0;
    endtask

    task automatic bus_stop();
        #(Q) m_sda = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) m_sda = 1'b1;
        #(Q);
    endtask

    task automatic write_bit(input logic b);
        #(Q) m_sda = b;
        #(Q) scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        #(2*Q) scl = 1'b1;
        #(Q) b = sda;
        #(Q) scl = 1'b0;
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic a;
        exp_q.push_back({15'd0, exp_ack});
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        sb_check(tag, {15'd0, a});
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp, input logic mack);
        logic       b;
        logic [7:0] r;
        r = 8'h00;
        exp_q.push_back({8'h00, exp});
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            r = {r[6:0], b};
        end
        write_bit(mack);
        sb_check(tag, {8'h00, r});
    endtask

    task automatic check_data(input string tag, input logic [15:0] exp);
        exp_q.push_back(exp);
        #(Q);
        sb_check(tag, i2c_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] addr_w;
        logic [7:0] addr_r;
        addr_w = 8'hA0;
        addr_r = 8'hA1;

        #(50);
        check_val("reset_data", i2c_data, 16'h0000);
        check_val("reset_sda", {15'd0, sda}, 16'h0001);
        rst = 1'b0;
        #(4*Q);

        // Basic write 0x00, 0x45
        bus_start();
        write_byte("w1_addr_ack", addr_w, 1'b0);
        write_byte("w1_d0_ack", 8'h00, 1'b0);
        write_byte("w1_d1_ack", 8'h45, 1'b0);
        bus_stop();
        check_data("w1_data", 16'h0045);

        // Wrong address: NACK and register untouched
        bus_start();
        write_byte("nack_addr", 8'hA2, 1'b1);
        bus_stop();
        check_data("nack_data", 16'h0045);

        // Next valid transfer loads 0x1234
        bus_start();
        write_byte("w2_addr_ack", addr_w, 1'b0);
        write_byte("w2_d0_ack", 8'h12, 1'b0);
        write_byte("w2_d1_ack", 8'h34, 1'b0);
        bus_stop();
        check_data("w2_data", 16'h1234);

        // Read back: master ACKs first byte, NACKs second
        bus_start();
        write_byte("r1_addr_ack", addr_r, 1'b0);
        read_byte("r1_byte0", 8'h12, 1'b0);
        read_byte("r1_byte1", 8'h34, 1'b1);
        #(Q);
        check_val("r1_sda_released", {15'd0, sda}, 16'h0001);
        bus_stop();
        check_data("r1_data", 16'h1234);

        // Write then repeated START into a read
        bus_start();
        write_byte("rs_addr_w_ack", addr_w, 1'b0);
        write_byte("rs_d0_ack", 8'hAA, 1'b0);
        bus_start();
        write_byte("rs_addr_r_ack", addr_r, 1'b0);
        read_byte("rs_byte0", 8'h34, 1'b0);
        read_byte("rs_byte1", 8'hAA, 1'b1);
        bus_stop();
        check_data("rs_data", 16'h34AA);

        // Three bytes: only the last two survive
        bus_start();
        write_byte("w3_addr_ack", addr_w, 1'b0);
        write_byte("w3_d0_ack", 8'h11, 1'b0);
        write_byte("w3_d1_ack", 8'h22, 1'b0);
        write_byte("w3_d2_ack", 8'h33, 1'b0);
        bus_stop();
        check_data("w3_data", 16'h2233);

        // Reset while the slave is holding the address ACK low
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
        m_sda = 1'b1;
        #(2*Q);
        check_val("pre_rst_ack_low", {15'd0, sda}, 16'h0000);
        rst = 1'b1;
        #1;
        check_val("rst_sda_released", {15'd0, sda}, 16'h0001);
        check_val("rst_data", i2c_data, 16'h0000);
        #(Q) rst = 1'b0;
        #(Q) scl = 1'b1;
        #(2*Q);

        // Transfer after reset works normally
        bus_start();
        write_byte("w4_addr_ack", addr_w, 1'b0);
        write_byte("w4_d0_ack", 8'h00, 1'b0);
        write_byte("w4_d1_ack", 8'h45, 1'b0);
        bus_stop();
        check_data("w4_data", 16'h0045);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_vip_core.md
# i2c_slave_vip_core

Behavioural-synthesizable I2C slave used in the SoC testbench to terminate the `i2c_cl_0`/`i2c_da_0` pins of the I2C master controller. It oversamples SCL/SDA on the system clock, detects START/STOP, and acknowledges its 7-bit address. It shifts received write bytes into a 16-bit capture register. For reads it returns that register's bytes, so the bench can check master transfers (for example, writing 0x00,0x45 yields `i2c_data == 69`).

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address the slave acknowledges.
- `clk`  input  1: system clock (HCLK); all logic on rising edge.
- `rst`  input  1: asynchronous, active-high reset (bench drives `~HRESETn`).
- `scl`  input  1: I2C clock, externally pulled up; never driven.
- `sda`  inout  1: I2C data, open-drain; driven only to 0 or high-Z.
- `i2c_data`  output  16: capture register, most recent two write data bytes.

## Operation
- Input conditioning:
  - `scl` and `sda` each pass through a 2-flop synchronizer (high-Z/X reads as 1).
  - Edge detection then compares the synchronized value with its previous sample.
- START: synced SDA falls while synced SCL is high. It is accepted from any state, including a repeated START mid-transfer. Effects: bit counter = 0, state = ADDR, SDA released.
- STOP: synced SDA rises while synced SCL is high. Effects: state = IDLE, SDA released.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: sample 8 bits MSB-first on SCL rising edges (7 address bits + R/W). After the 8th bit:
    - address match: go to ADDR_ACK;
    - mismatch: go to IGNORE.
  - ADDR_ACK: ACK slot. Then R/W=0 goes to WR_DATA; R/W=1 loads the read shift register with `i2c_data[15:8]` and goes to RD_DATA.
  - WR_DATA: sample 8 bits. After the 8th bit: `i2c_data <= {i2c_data[7:0], byte}`, then go to WR_ACK.
  - WR_ACK: ACK slot, then back to WR_DATA.
  - RD_DATA: shift 8 bits out MSB-first; a 0 bit drives SDA low, a 1 bit releases it. Then go to RD_ACK.
  - RD_ACK: SDA released; sample the master's bit on SCL rising edge.
    - ACK (0): load the alternate byte (low byte after high, high after low) and return to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- General-call address 0x00 is treated like any other non-matching address.
- Bytes are not counted: writes of any length keep shifting into `i2c_data`.

## Timing
- Reset values: `i2c_data` = 16'h0000, SDA released, state IDLE, counters 0. Reset asserted mid-transfer releases SDA immediately (asynchronously).
- Sampling: on the clk cycle where synced SCL is seen rising.
- SDA updates (ACK drive, ACK release, read-bit change): on the clk cycle where synced SCL is seen falling. The ACK drive therefore starts on the falling edge after bit 8 and is released on the next falling edge.
- Latency from a pin edge to an internal action is 3 clk cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- Requirements on the master and clock:
  - the master's SDA hold after SCL falls must exceed 3 clk periods;
  - clk must be at least 8× the SCL frequency.
- START/STOP detection has priority over bit sampling in the same cycle.
- `i2c_data` updates on the cycle the 8th write bit is sampled, before the ACK slot.

## Structure
- Package `i2c_vip_pkg`:
  - state enum: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE;
  - constant `I2C_DEFAULT_ADDR` = 7'h50.
- One sub-module, `i2c_sync_edge`: 2-flop synchronizer plus rise/fall detect, instantiated once for SCL and once for SDA.
- The FSM, bit counter, shift registers and open-drain driver live in the top level.

## Test plan
- Reset: assert `rst` mid-byte -> `i2c_data` == 0, SDA high-Z, next START is handled normally.
- Write 0x50/W, 0x00, 0x45, STOP -> ACK low on all three 9th clocks; `i2c_data` == 16'h0045 (69).
- Write to address 0x51 -> SDA never driven low (NACK); `i2c_data` unchanged; the next valid transfer works.
- With `i2c_data` = 16'h1234: read 0x50/R, master ACKs, then NACKs -> bytes 0x12 then 0x34, SDA released after the NACK.
- Write 0xAA, then repeated START with 0x50/R, without STOP -> re-addressed and ACKed; the read returns the updated register.
- Three write bytes 0x11, 0x22, 0x33 -> `i2c_data` == 16'h2233.
